// File: rtl/pc_pkg.sv
// ---------------------------------------------------------------------------
// pc_pkg
// Shared definitions for the IF-stage program counter sequencer.
//   - pc_state_e : fetch FSM states (BOOT / RUN / HOLD), 2-bit encoding
//   - XLEN, PC_INC, default reset PC and trap vector
//   - align_pc() : forces a redirect target onto a 4-byte boundary
// Optional feature macro used by the importing files: PC_TRAP_EN
// ---------------------------------------------------------------------------
package pc_pkg;

    localparam int XLEN = 32;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } pc_state_e;

    localparam logic [XLEN-1:0] PC_INC           = 32'd4;
    localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;
    localparam logic [XLEN-1:0] DEFAULT_TRAP_VEC = 32'h0000_0100;

    function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] target);
        return {target[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/pc_redirect_buf.sv
// ---------------------------------------------------------------------------
// pc_redirect_buf
// Holds one pending redirect target that could not be taken because the
// fetch did not advance in the cycle the redirect arrived.
// Ports:
//   clk, rst  : clock, synchronous active-high reset
//   load      : capture target, set pend_v (a newer load overwrites an older)
//   target    : already-aligned redirect address
//   consume   : pending target used by the PC this cycle -> clear pend_v
//   clr       : discard any pending target (superseded by a taken redirect)
//   pend_v    : a pending target is held
//   pend_pc   : the pending target
// load never coincides with consume/clr in the parent (load only happens on
// non-advancing cycles, the others only on advancing cycles).
// ---------------------------------------------------------------------------
module pc_redirect_buf
    import pc_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            load,
    input  logic [XLEN-1:0] target,
    input  logic            consume,
    input  logic            clr,
    output logic            pend_v,
    output logic [XLEN-1:0] pend_pc
);

    logic            pend_v_q,  pend_v_d;
    logic [XLEN-1:0] pend_pc_q, pend_pc_d;

    always_comb begin
        pend_v_d  = pend_v_q;
        pend_pc_d = pend_pc_q;
        if (load) begin
            pend_v_d  = 1'b1;
            pend_pc_d = target;
        end else if (consume || clr) begin
            pend_v_d  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pend_v_q  <= 1'b0;
            pend_pc_q <= '0;
        end else begin
            pend_v_q  <= pend_v_d;
            pend_pc_q <= pend_pc_d;
        end
    end

    assign pend_v  = pend_v_q;
    assign pend_pc = pend_pc_q;

endmodule

// File: rtl/pc_sequencer.sv
// ---------------------------------------------------------------------------
// pc_sequencer
// Owns the IF-stage program counter (PCF) and sequences instruction fetch.
// Ports:
//   clk, rst       : clock, synchronous active-high reset
//   stall_f        : hazard unit hold of PCF
//   PCSrcE         : EX-stage taken branch / jump
//   JumpTarget_E   : EX-stage redirect target (bits [1:0] dropped on load)
//   imem_ready     : imem accepts the address presented this cycle
//   imem_req       : fetch request, address is PCF
//   PCF, PCplus4F  : current fetch PC and PCF+4 (combinational)
//   flush_d/e      : clear IF/ID, ID/EX at next edge
//   dbg_state      : current FSM state, for observation
//   dbg_pend_v     : a buffered redirect is pending, for observation
//   trap_req, trap_epc_in, epc_q : present only with PC_TRAP_EN defined
// Handshake: an address is accepted on any cycle where imem_req and
// imem_ready are both high; PCF only moves on such a cycle when stall_f is
// low (adv). A redirect that arrives without adv is buffered and taken on
// the next adv cycle.
// Optional feature macro: PC_TRAP_EN (trap vectoring + exception PC latch).
// ---------------------------------------------------------------------------
module pc_sequencer
    import pc_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC
`ifdef PC_TRAP_EN
    ,
    parameter logic [XLEN-1:0] TRAP_VEC = DEFAULT_TRAP_VEC
`endif
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall_f,
    input  logic            PCSrcE,
    input  logic [XLEN-1:0] JumpTarget_E,
    input  logic            imem_ready,
    output logic            imem_req,
    output logic [XLEN-1:0] PCF,
    output logic [XLEN-1:0] PCplus4F,
    output logic            flush_d,
    output logic            flush_e,
    output pc_state_e       dbg_state,
    output logic            dbg_pend_v
`ifdef PC_TRAP_EN
    ,
    input  logic            trap_req,
    input  logic [XLEN-1:0] trap_epc_in,
    output logic [XLEN-1:0] epc_q
`endif
);

    pc_state_e       state_q, state_d;
    logic [XLEN-1:0] pcf_q, pcf_d;

    logic            adv;
    logic            trap_c;
    logic            redirect;
    logic [XLEN-1:0] redirect_target;
    logic            pend_v;
    logic [XLEN-1:0] pend_pc;
    logic            pend_load;
    logic            pend_consume;
    logic            pend_clr;

`ifdef PC_TRAP_EN
    logic [XLEN-1:0] epc_d;
    assign trap_c          = trap_req;
    assign redirect_target = trap_req ? TRAP_VEC : align_pc(JumpTarget_E);
`else
    assign trap_c          = 1'b0;
    assign redirect_target = align_pc(JumpTarget_E);
`endif

    // ---------------- fetch FSM ----------------
    always_comb begin
        state_d  = state_q;
        imem_req = 1'b0;
        case (state_q)
            BOOT: begin
                state_d = RUN;
            end
            RUN: begin
                imem_req = 1'b1;
                if (!imem_ready) state_d = HOLD;
            end
            HOLD: begin
                imem_req = 1'b1;
                if (imem_ready) state_d = RUN;
            end
            default: begin
                state_d = BOOT;
            end
        endcase
    end

    assign adv      = imem_req & imem_ready & ~stall_f;
    assign redirect = PCSrcE | trap_c;

    // Every advancing cycle either takes a fresh redirect (which makes any
    // older buffered one stale) or drains the buffer, so pend_v never
    // survives an adv cycle.
    assign pend_load    = redirect & ~adv;
    assign pend_consume = adv & pend_v & ~redirect;
    assign pend_clr     = adv & redirect;

    // ---------------- next PC ----------------
    always_comb begin
        pcf_d = pcf_q;
        if (adv) begin
            if (redirect)    pcf_d = redirect_target;
            else if (pend_v) pcf_d = pend_pc;
            else             pcf_d = pcf_q + PC_INC;
        end
    end

    // ---------------- flushes ----------------
    // Redirect flushes are Mealy on the request itself, even if stalled, so
    // the wrong-path instructions are killed while the target waits.
    always_comb begin
        flush_e = redirect & (state_q != BOOT);
        flush_d = flush_e | pend_consume;
    end

`ifdef PC_TRAP_EN
    always_comb begin
        epc_d = epc_q;
        if (trap_req) epc_d = trap_epc_in;
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= BOOT;
            pcf_q   <= RESET_PC;
`ifdef PC_TRAP_EN
            epc_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            pcf_q   <= pcf_d;
`ifdef PC_TRAP_EN
            epc_q   <= epc_d;
`endif
        end
    end

    pc_redirect_buf u_redirect_buf (
        .clk     (clk),
        .rst     (rst),
        .load    (pend_load),
        .target  (redirect_target),
        .consume (pend_consume),
        .clr     (pend_clr),
        .pend_v  (pend_v),
        .pend_pc (pend_pc)
    );

    assign PCF        = pcf_q;
    assign PCplus4F   = pcf_q + PC_INC;
    assign dbg_state  = state_q;
    assign dbg_pend_v = pend_v;

endmodule
